// File: rtl/cskipa_pipe_adder.sv
// rtl/cskipa_pipe_adder.sv - pipelined carry-skip adder/subtractor with valid/ready handshake
module cskipa_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4,
  parameter int NSTG  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int SW = WIDTH / NSTG;
  localparam int NB = SW / BLK;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if ((WIDTH % (BLK * NSTG)) != 0 || NSTG < 1 || NSTG > (WIDTH / BLK)) begin : g_bad_params
      $error("cskipa_pipe_adder: WIDTH must be a multiple of BLK*NSTG and NSTG in 1..WIDTH/BLK");
    end
  endgenerate

  // Per-stage beat registers: operands travel with the beat so later stages see their own upper bits.
  logic [NSTG-1:0]  v_q;
  logic [NSTG-1:0]  c_q;
  logic [WIDTH-1:0] a_q [NSTG];
  logic [WIDTH-1:0] b_q [NSTG];
  logic [WIDTH-1:0] s_q [NSTG];
  logic             ovf_q;

  logic [NSTG-1:0]  adv;
  logic [NSTG-1:0]  v_src;
  logic [NSTG-1:0]  c_src;
  logic [NSTG-1:0]  c_nx;
  logic [WIDTH-1:0] a_src [NSTG];
  logic [WIDTH-1:0] b_src [NSTG];
  logic [WIDTH-1:0] s_src [NSTG];
  logic [WIDTH-1:0] s_nx  [NSTG];
  logic             ovf_nx;

  // Stage k may advance when any stage from k to the output is empty or the output is drained;
  // written in closed form so no stage depends on a neighbour's advance signal.
  always_comb begin
    logic full;
    adv = '0;
    for (int k = 0; k < NSTG; k++) begin
      full = 1'b1;
      for (int j = k; j < NSTG; j++) begin
        full = full & v_q[j];
      end
      adv[k] = i_ready | ~full;
    end
  end

  // Stage inputs: stage 0 takes the port operands (B inverted for subtract), later stages the previous register.
  always_comb begin
    a_src[0] = i_add_term1;
    b_src[0] = i_sub ? ~i_add_term2 : i_add_term2;
    c_src[0] = i_sub | i_cin;
    s_src[0] = '0;
    v_src[0] = i_valid;
    for (int k = 1; k < NSTG; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      c_src[k] = c_q[k-1];
      s_src[k] = s_q[k-1];
      v_src[k] = v_q[k-1];
    end
  end

  // Carry-skip slice per stage: ripple inside each block, skip mux selects block carry-in when all bits propagate.
  always_comb begin
    logic           c;
    logic           cb;
    logic           rc;
    logic           p;
    logic           ab;
    logic           cm;
    logic [IW-1:0]  idx;
    ovf_nx = 1'b0;
    c      = 1'b0;
    cb     = 1'b0;
    rc     = 1'b0;
    p      = 1'b0;
    ab     = 1'b0;
    cm     = 1'b0;
    idx    = '0;
    for (int k = 0; k < NSTG; k++) begin
      s_nx[k] = s_src[k];
      c       = c_src[k];
      cm      = 1'b0;
      for (int blk = 0; blk < NB; blk++) begin
        cb = c;
        rc = c;
        p  = 1'b1;
        for (int i = 0; i < BLK; i++) begin
          idx = IW'(k * SW + blk * BLK + i);
          ab  = a_src[k][idx] ^ b_src[k][idx];
          s_nx[k][idx] = ab ^ rc;
          if (idx == IW'(WIDTH - 1)) cm = rc;
          p  = p & ab;
          rc = (a_src[k][idx] & b_src[k][idx]) | (rc & ab);
        end
        c = p ? cb : rc;
      end
      c_nx[k] = c;
      if (k == NSTG - 1) ovf_nx = c ^ cm;
    end
  end

  // Pipeline registers: a stage loads only on advance; data registers load only for a valid beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_src[k];
          if (v_src[k]) begin
            a_q[k] <= a_src[k];
            b_q[k] <= b_src[k];
            s_q[k] <= s_nx[k];
            c_q[k] <= c_nx[k];
          end
        end
      end
      if (adv[NSTG-1] && v_src[NSTG-1]) ovf_q <= ovf_nx;
    end
  end

  assign o_ready = adv[0];
  assign o_valid = v_q[NSTG-1];
  assign o_sum   = s_q[NSTG-1];
  assign o_cout  = c_q[NSTG-1];
  assign o_ovf   = ovf_q;

endmodule
